// File: rtl/picoblaze_io_intc.sv
// rtl/picoblaze_io_intc.sv - I/O port decoder and interrupt controller for pacoblaze3
module picoblaze_io_intc #(
  parameter int NUM_IN         = 4,
  parameter int NUM_OUT        = 4,
  parameter int NUM_IRQ        = 4,
  parameter int CLK_FREQ_IN_HZ = 25000000,
  parameter int TICK_HZ        = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [7:0]           port_id_i,
  input  logic [7:0]           out_port_i,
  input  logic                 write_strobe_i,
  input  logic                 read_strobe_i,
  output logic [7:0]           in_port_o,
  output logic                 interrupt_o,
  input  logic                 interrupt_ack_i,
  input  logic [8*NUM_IN-1:0]  in_data_i,
  output logic [8*NUM_OUT-1:0] out_data_o,
  output logic [NUM_OUT-1:0]   out_wr_o,
  input  logic [NUM_IRQ-1:0]   irq_src_i,
  output logic                 tick_o
);

  // Source NUM_IRQ is the internal tick; the others are external edges.
  localparam int NSRC = NUM_IRQ + 1;
  localparam int P    = CLK_FREQ_IN_HZ / TICK_HZ;
  localparam int CW   = (P > 2) ? $clog2(P) : 1;

  localparam logic [7:0] ADDR_STATUS = 8'hF0;
  localparam logic [7:0] ADDR_MASK   = 8'hF1;
  localparam logic [7:0] ADDR_CLEAR  = 8'hF2;
  localparam logic [7:0] ADDR_CTRL   = 8'hF3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]           in_port_q, in_port_d;
  logic [8*NUM_OUT-1:0] out_data_q, out_data_d;
  logic [NUM_OUT-1:0]   out_wr_q, out_wr_d;
  logic [NSRC-1:0]      mask_q, mask_d;
  logic [NSRC-1:0]      pending_q, pending_d;
  logic                 tick_en_q, tick_en_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_IRQ-1:0]   sync1_q, sync2_q, edge_q;

  logic            wr_mask, wr_clear, wr_ctrl;
  logic            tick_hit;
  logic            req;
  logic [NSRC-1:0] set_vec, clr_vec;

  // Reads never have side effects; the strobe is accepted but not needed.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe_i;

  assign wr_mask  = write_strobe_i && (port_id_i == ADDR_MASK);
  assign wr_clear = write_strobe_i && (port_id_i == ADDR_CLEAR);
  assign wr_ctrl  = write_strobe_i && (port_id_i == ADDR_CTRL);

  assign tick_hit = (cnt_q == CW'(P - 1));
  assign req      = |(pending_q & mask_q);

  assign in_port_o   = in_port_q;
  assign out_data_o  = out_data_q;
  assign out_wr_o    = out_wr_q;
  assign tick_o      = tick_hit;
  assign interrupt_o = (state_q == ST_ASSERT);

  // Read mux: control registers first, then input ports, else zero.
  always_comb begin
    in_port_d = 8'h00;
    case (port_id_i)
      ADDR_STATUS: in_port_d = 8'(pending_q);
      ADDR_MASK:   in_port_d = 8'(mask_q);
      ADDR_CLEAR:  in_port_d = 8'h00;
      ADDR_CTRL:   in_port_d = {7'b0, tick_en_q};
      default: begin
        for (int p = 0; p < NUM_IN; p++) begin
          if (port_id_i == 8'(p)) in_port_d = in_data_i[8*p +: 8];
        end
      end
    endcase
  end

  // Output port writes and their one-cycle strobes.
  always_comb begin
    out_data_d = out_data_q;
    out_wr_d   = '0;
    if (write_strobe_i) begin
      for (int p = 0; p < NUM_OUT; p++) begin
        if (port_id_i == 8'(p)) begin
          out_data_d[8*p +: 8] = out_port_i;
          out_wr_d[p]          = 1'b1;
        end
      end
    end
  end

  // Pending/mask/ctrl/timer next state; a new set beats a same-cycle W1C.
  always_comb begin
    set_vec   = {tick_hit & tick_en_q, sync2_q & ~edge_q};
    clr_vec   = wr_clear ? out_port_i[NSRC-1:0] : '0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    mask_d    = wr_mask ? out_port_i[NSRC-1:0] : mask_q;
    tick_en_d = wr_ctrl ? out_port_i[0] : tick_en_q;
    cnt_d     = tick_hit ? '0 : cnt_q + 1'b1;
  end

  // Service FSM: hold the request until acked, then wait for the ISR clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req) state_d = ST_ASSERT;
      ST_ASSERT:  if (interrupt_ack_i) state_d = ST_SERVICE;
      ST_SERVICE: if (wr_clear) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_port_q  <= 8'h00;
      out_data_q <= '0;
      out_wr_q   <= '0;
      mask_q     <= '0;
      pending_q  <= '0;
      tick_en_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      in_port_q  <= in_port_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      tick_en_q  <= tick_en_d;
      cnt_q      <= cnt_d;
    end
  end

  // Two-flop synchroniser followed by the edge-history register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

endmodule

// File: tb/tb_picoblaze_io_intc.sv
// tb/tb_picoblaze_io_intc.sv - self-checking bench for picoblaze_io_intc
module tb_picoblaze_io_intc;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int NUM_IRQ = 4;
  localparam int PERIOD  = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  port_id, out_port, in_port;
  logic        write_strobe, read_strobe, interrupt, interrupt_ack, tick;
  logic [31:0] in_data, out_data;
  logic [3:0]  out_wr;
  logic [3:0]  irq_src;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  pid;
    logic [31:0] din;
    logic [7:0]  exp;
  } rd_vec_t;

  typedef struct {
    logic [7:0]  pid;
    logic [7:0]  data;
    logic [31:0] exp_out;
    logic [3:0]  exp_wr;
  } wr_vec_t;

  rd_vec_t rd_tab[9];
  wr_vec_t wr_tab[5];
  logic [7:0] mdl_out[4];

  picoblaze_io_intc #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .NUM_IRQ(NUM_IRQ),
    .CLK_FREQ_IN_HZ(PERIOD), .TICK_HZ(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .port_id_i(port_id), .out_port_i(out_port),
    .write_strobe_i(write_strobe), .read_strobe_i(read_strobe), .in_port_o(in_port),
    .interrupt_o(interrupt), .interrupt_ack_i(interrupt_ack), .in_data_i(in_data),
    .out_data_o(out_data), .out_wr_o(out_wr), .irq_src_i(irq_src), .tick_o(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 5 && !ok; i++) begin
      if (tick) ok = 1'b1;
      else step();
    end
    if (!ok) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0]  pid, d;
    logic [31:0] exp_out;

    rd_tab[0] = '{8'h01, 32'h00003C00, 8'h3C};
    rd_tab[1] = '{8'h40, 32'h00003C00, 8'h00};
    rd_tab[2] = '{8'h03, 32'hDEADBEEF, 8'hDE};
    rd_tab[3] = '{8'h00, 32'hDEADBEEF, 8'hEF};
    rd_tab[4] = '{8'h04, 32'hDEADBEEF, 8'h00};
    rd_tab[5] = '{8'hF2, 32'hDEADBEEF, 8'h00};
    rd_tab[6] = '{8'hF0, 32'h12345678, 8'h00};
    rd_tab[7] = '{8'hF3, 32'h12345678, 8'h00};
    rd_tab[8] = '{8'hFF, 32'h12345678, 8'h00};

    wr_tab[0] = '{8'h00, 8'h11, 32'h00A50011, 4'b0001};
    wr_tab[1] = '{8'h03, 8'h77, 32'h77A50011, 4'b1000};
    wr_tab[2] = '{8'h04, 8'h99, 32'h77A50011, 4'b0000};
    wr_tab[3] = '{8'hF0, 8'h55, 32'h77A50011, 4'b0000};
    wr_tab[4] = '{8'h01, 8'hFF, 32'h77A5FF11, 4'b0010};

    reset_n = 1'b0; port_id = 8'h80; out_port = 8'h00; write_strobe = 1'b0;
    read_strobe = 1'b0; interrupt_ack = 1'b0; in_data = 32'h0; irq_src = 4'h0;
    repeat (3) step();
    chk("rst_in_port", in_port, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_interrupt", interrupt, 0);
    chk("rst_tick", tick, 0);
    reset_n = 1'b1;
    step();

    // Single write to port 2
    wr(8'h02, 8'hA5);
    chk("wr2_out_data", out_data, 32'h00A50000);
    chk("wr2_out_wr", out_wr, 4'b0100);
    step();
    chk("wr2_out_wr_drop", out_wr, 4'b0000);
    chk("wr2_out_data_hold", out_data, 32'h00A50000);

    foreach (wr_tab[i]) begin
      wr(wr_tab[i].pid, wr_tab[i].data);
      chk($sformatf("wrtab%0d_data", i), out_data, wr_tab[i].exp_out);
      chk($sformatf("wrtab%0d_wr", i), out_wr, wr_tab[i].exp_wr);
    end
    step();

    foreach (rd_tab[i]) begin
      in_data = rd_tab[i].din;
      port_id = rd_tab[i].pid;
      step();
      chk($sformatf("rdtab%0d", i), in_port, rd_tab[i].exp);
    end

    // Randomised port traffic against a byte-array model
    mdl_out[0] = 8'h11; mdl_out[1] = 8'hFF; mdl_out[2] = 8'hA5; mdl_out[3] = 8'h77;
    for (int it = 0; it < 120; it++) begin
      pid = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        wr(pid, d);
        if (pid < NUM_OUT) mdl_out[pid] = d;
        exp_out = {mdl_out[3], mdl_out[2], mdl_out[1], mdl_out[0]};
        chk("rnd_wr_data", out_data, exp_out);
        chk("rnd_wr_strobe", out_wr, (pid < NUM_OUT) ? (32'd1 << pid) : 32'd0);
      end else begin
        in_data = $urandom;
        port_id = pid;
        step();
        chk("rnd_rd", in_port, (pid < NUM_IN) ? ((in_data >> (8 * pid)) & 32'hFF) : 32'd0);
      end
    end

    // External source latency, ack and clear
    wr(8'hF1, 8'h01);
    port_id = 8'hF0;
    irq_src = 4'b0001;
    step(); step(); step();
    chk("irq_e3_status_old", in_port, 8'h00);
    chk("irq_e3_int", interrupt, 0);
    step();
    chk("irq_e4_status", in_port, 8'h01);
    chk("irq_e4_int", interrupt, 1);
    ack();
    chk("ack_int_low", interrupt, 0);
    repeat (4) step();
    chk("service_int_low", interrupt, 0);
    wr(8'hF2, 8'h01);
    port_id = 8'hF0;
    step();
    chk("clear_status", in_port, 8'h00);
    chk("clear_int_low", interrupt, 0);

    // W1C colliding with a new edge: set wins, then reassert
    irq_src = 4'b0000;
    repeat (4) step();
    irq_src = 4'b0001;
    step(); step();
    wr(8'hF2, 8'h01);
    port_id = 8'hF0;
    step();
    chk("collision_status", in_port, 8'h01);
    chk("collision_reassert", interrupt, 1);
    ack();
    wr(8'hF2, 8'h01);
    step();
    chk("collision_done_int", interrupt, 0);

    // Unmasking an already pending source; ASSERT survives mask drop
    irq_src = 4'b0011;
    repeat (4) step();
    port_id = 8'hF0;
    step();
    chk("masked_status", in_port, 8'h02);
    chk("masked_int", interrupt, 0);
    wr(8'hF1, 8'h02);
    step();
    chk("unmask_int", interrupt, 1);
    port_id = 8'hF0;
    step();
    chk("unmask_status", in_port, 8'h02);
    wr(8'hF1, 8'h00);
    step();
    chk("assert_hold", interrupt, 1);
    ack();
    chk("hold_ack", interrupt, 0);
    wr(8'hF2, 8'h02);
    irq_src = 4'b0000;
    step();

    // Tick period with tick_en=0, then with tick_en=1
    wait_tick(ok);
    if (ok) begin
      step();
      chk("tick_width", tick, 0);
      n = 1;
      while (!tick && n < 2 * PERIOD + 5) begin
        step();
        n++;
      end
      chk("tick_period", n, PERIOD);
      step();
      port_id = 8'hF0;
      step();
      chk("tick_no_pend", in_port, 8'h00);
    end
    wr(8'hF3, 8'h01);
    wr(8'hF1, 8'h10);
    port_id = 8'hF3;
    step();
    chk("ctrl_readback", in_port, 8'h01);
    wait_tick(ok);
    step(); step();
    chk("tick_int", interrupt, 1);
    port_id = 8'hF0;
    step();
    chk("tick_pend", in_port, 8'h10);

    // Asynchronous reset while interrupt is asserted
    wr(8'h00, 8'h5A);
    chk("pre_reset_int", interrupt, 1);
    #2 reset_n = 1'b0;
    #2;
    chk("areset_int", interrupt, 0);
    chk("areset_out_data", out_data, 0);
    chk("areset_in_port", in_port, 0);
    #2 reset_n = 1'b1;
    step();
    chk("post_reset_int", interrupt, 0);
    port_id = 8'hF1;
    step();
    chk("post_reset_mask", in_port, 0);
    port_id = 8'hF0;
    step();
    chk("post_reset_status", in_port, 0);
    repeat (PERIOD + 3) step();
    chk("post_reset_idle", interrupt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
